// File: rtl/aes128_round_sequencer.sv
// aes128_round_sequencer: iterative AES-128 encryptor, one round per cycle, round keys expanded on the fly
// Ports:
//   clk, rst (async, active-low)
//   in_valid/in_ready, in_key, in_block   : block source handshake; key and block sampled on acceptance
//   out_valid/out_ready, out_block        : ciphertext sink handshake; out_block held until taken
//   flush                                 : synchronous abort back to IDLE
//   busy, round_idx                       : status (RUN or DONE; current round, 0 when idle)
module aes128_round_sequencer #(
    parameter int ROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_key,
    input  logic [127:0] in_block,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_block,
    input  logic         flush,
    output logic         busy,
    output logic [3:0]   round_idx
);
    typedef logic [3:0][3:0][7:0] mat_t;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    if (ROUNDS != 10) begin : g_bad_rounds
        $error("aes128_round_sequencer supports only ROUNDS=10");
    end

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // byte n of the word sits at row n%4, col n/4
    function automatic mat_t to_mat(input logic [127:0] w);
        mat_t m;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                m[r][c] = w[127-8*(4*c+r) -: 8];
        return m;
    endfunction

    function automatic logic [127:0] from_mat(input mat_t m);
        logic [127:0] w;
        w = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                w[127-8*(4*c+r) -: 8] = m[r][c];
        return w;
    endfunction

    function automatic mat_t sub_bytes(input mat_t m);
        mat_t o;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[r][c] = SBOX[m[r][c]];
        return o;
    endfunction

    function automatic mat_t shift_rows(input mat_t m);
        mat_t o;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[r][c] = m[r][(c+r)%4];
        return o;
    endfunction

    function automatic mat_t mix_columns(input mat_t m);
        mat_t o;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = m[0][c];
            a1 = m[1][c];
            a2 = m[2][c];
            a3 = m[3][c];
            o[0][c] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[1][c] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[2][c] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[3][c] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    state_t       state, state_next;
    logic [127:0] state_reg, key_reg, next_key, std_out, fin_out;
    logic [7:0]   rcon;
    logic [31:0]  w0, w1, w2, w3;
    logic         last_round;

    assign last_round = round_idx == 4'(ROUNDS);

    always_comb begin
        w0 = key_reg[127:96] ^ sub_word({key_reg[23:0], key_reg[31:24]}) ^ {rcon, 24'h0};
        w1 = key_reg[95:64] ^ w0;
        w2 = key_reg[63:32] ^ w1;
        w3 = key_reg[31:0] ^ w2;
        next_key = {w0, w1, w2, w3};
        std_out = from_mat(mix_columns(shift_rows(sub_bytes(to_mat(state_reg))))) ^ next_key;
        fin_out = from_mat(shift_rows(sub_bytes(to_mat(state_reg)))) ^ next_key;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // flush outranks both acceptance and the output handshake
    always_comb begin
        state_next = flush                          ? IDLE :
                     (state == IDLE && in_valid)    ? RUN  :
                     (state == RUN && last_round)   ? DONE :
                     (state == DONE && out_ready)   ? IDLE : state;
        in_ready   = state == IDLE;
        out_valid  = state == DONE;
        busy       = state != IDLE;
        out_block  = state == DONE ? state_reg : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= '0;
            key_reg   <= '0;
            rcon      <= 8'h01;
            round_idx <= '0;
        end else if (flush) begin
            round_idx <= '0;
        end else if (state == IDLE && in_valid) begin
            state_reg <= in_block ^ in_key;
            key_reg   <= in_key;
            rcon      <= 8'h01;
            round_idx <= 4'd1;
        end else if (state == RUN) begin
            state_reg <= last_round ? fin_out : std_out;
            key_reg   <= next_key;
            rcon      <= xtime(rcon);
            round_idx <= last_round ? 4'd0 : round_idx + 4'd1;
        end
    end
endmodule

// File: tb/tb_aes128_round_sequencer.sv
// tb_aes128_round_sequencer: scoreboard bench for the iterative AES-128 sequencer
module tb_aes128_round_sequencer;
    logic         clk = 0;
    logic         rst;
    logic         in_valid, in_ready, out_valid, out_ready, flush, busy;
    logic [127:0] in_key, in_block, out_block;
    logic [3:0]   round_idx;
    int           checks = 0, failures = 0, cyc = 0;
    logic [127:0] exp_q[$];

    localparam logic [127:0] K_C1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] RK1_B = 128'ha0fafe1788542cb123a339392a6c7605;

    aes128_round_sequencer dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_key(in_key), .in_block(in_block), .out_valid(out_valid),
        .out_ready(out_ready), .out_block(out_block), .flush(flush),
        .busy(busy), .round_idx(round_idx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // scoreboard monitor: every completed output transfer pops one expected ciphertext
    always @(negedge clk) begin
        if (rst && out_valid && out_ready && !flush) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output actual=%h required=none", out_block);
            end else begin
                chk("ciphertext", out_block, exp_q.pop_front());
            end
        end
    end

    task automatic accept(input logic [127:0] k, input logic [127:0] pt, input bit push,
                          input logic [127:0] exp, input bit keep, output int t);
        bit ok;
        in_key = k;
        in_block = pt;
        in_valid = 1;
        ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
        end
        if (!ok) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        t = cyc;
        if (push) exp_q.push_back(exp);
        in_valid = keep;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 && !in_ready; i++) begin
            @(posedge clk);
            #1;
        end
        chk("idle_reached", in_ready, 1);
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 40 && !out_valid; i++) begin
            @(posedge clk);
            #1;
        end
        chk("valid_reached", out_valid, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int t1, t2, n;
        rst = 0;
        in_valid = 0;
        out_ready = 1;
        flush = 0;
        in_key = '0;
        in_block = '0;
        #3;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_round_idx", round_idx, 0);
        chk("rst_out_block", out_block, 0);
        chk("rst_key_reg", dut.key_reg, 0);
        @(posedge clk);
        #1 rst = 1;

        // C.1 vector with latency measurement
        accept(K_C1, PT_C1, 1, CT_C1, 0, t1);
        chk("c1_round_idx_first", round_idx, 1);
        chk("c1_busy", busy, 1);
        chk("c1_in_ready_run", in_ready, 0);
        n = 0;
        while (!out_valid && n < 30) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("c1_latency_edges", n + 1, 11);
        @(posedge clk);
        #1;
        chk("c1_idle_after", in_ready, 1);

        // Appendix B vector with first round key inspection
        accept(K_B, PT_B, 1, CT_B, 0, t1);
        @(posedge clk);
        #1;
        chk("b_key_round1", dut.key_reg, RK1_B);
        chk("b_round_idx2", round_idx, 2);
        wait_idle();

        // output backpressure
        out_ready = 0;
        accept(K_C1, PT_C1, 1, CT_C1, 0, t1);
        wait_valid();
        repeat (20) begin
            @(posedge clk);
            #1;
            chk("bp_out_valid", out_valid, 1);
            chk("bp_out_block", out_block, CT_C1);
            chk("bp_in_ready", in_ready, 0);
        end
        out_ready = 1;
        @(posedge clk);
        #1;
        chk("bp_release_in_ready", in_ready, 1);
        chk("bp_release_out_valid", out_valid, 0);

        // back-to-back with in_valid held; inputs change while running
        accept(K_C1, PT_C1, 1, CT_C1, 1, t1);
        accept(K_B, PT_B, 1, CT_B, 0, t2);
        in_key = {4{32'hdeadbeef}};
        in_block = {4{32'h12345678}};
        in_valid = 0;
        chk("b2b_spacing", t2 - t1, 12);
        wait_idle();

        // flush at round 5, then a fresh block
        accept(K_C1, PT_C1, 0, '0, 0, t1);
        for (int i = 0; i < 20 && round_idx != 5; i++) begin
            @(posedge clk);
            #1;
        end
        chk("flush_round5_hit", round_idx, 5);
        flush = 1;
        @(posedge clk);
        #1 flush = 0;
        chk("flush_busy", busy, 0);
        chk("flush_round_idx", round_idx, 0);
        chk("flush_in_ready", in_ready, 1);
        repeat (12) @(posedge clk);
        #1;
        chk("flush_no_output", out_valid, 0);
        accept(K_B, PT_B, 1, CT_B, 0, t1);
        wait_idle();

        // flush beats acceptance in IDLE
        in_key = K_C1;
        in_block = PT_C1;
        in_valid = 1;
        flush = 1;
        #1;
        chk("flush_idle_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        chk("flush_idle_not_taken", busy, 0);
        in_valid = 0;
        flush = 0;

        // flush in DONE beats the output handshake
        out_ready = 0;
        accept(K_C1, PT_C1, 0, '0, 0, t1);
        wait_valid();
        flush = 1;
        out_ready = 1;
        @(posedge clk);
        #1 flush = 0;
        chk("flush_done_out_valid", out_valid, 0);
        chk("flush_done_busy", busy, 0);

        // asynchronous reset mid-run
        accept(K_B, PT_B, 0, '0, 0, t1);
        repeat (3) @(posedge clk);
        #3 rst = 0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_in_ready", in_ready, 1);
        chk("arst_out_valid", out_valid, 0);
        chk("arst_round_idx", round_idx, 0);
        chk("arst_out_block", out_block, 0);
        chk("arst_key_reg", dut.key_reg, 0);
        @(posedge clk);
        #1 rst = 1;
        accept(K_C1, PT_C1, 1, CT_C1, 0, t1);
        wait_idle();

        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/aes128_round_sequencer.md
Name: aes128_round_sequencer

Overview:
- Iterative AES-128 encryption engine controller. It time-multiplexes one standard-round datapath (sub_bytes, shift_rows, mix_columns, add_round_key) over rounds 1–9, and one final-round path (no mix_columns) for round 10.
- Generates round keys on the fly, one per cycle, from the cipher key.
- Sits between a block source and sink with valid/ready handshakes on both sides. Processes one block at a time.

Parameters:
- ROUNDS, 10, number of cipher rounds. Only 10 (AES-128) is supported; any other value is an elaboration error.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  asynchronous reset, active-low.
- in_valid  input  1  source offers a block.
- in_ready  output  1  sequencer accepts a block this cycle.
- in_key  input  128  cipher key. in_key[127:120] is key byte 0 (FIPS-197 order).
- in_block  input  128  plaintext. in_block[127:120] is byte 0.
- out_valid  output  1  ciphertext available.
- out_ready  input  1  sink accepts ciphertext.
- out_block  output  128  ciphertext, same byte order as in_block.
- flush  input  1  synchronous abort; discard any in-flight block.
- busy  output  1  high in RUN or DONE.
- round_idx  output  4  current round number, 0 in IDLE.

Behaviour:
- Internal matrices are [3:0][3:0][7:0] indexed [row][col]. Byte n of the 128-bit word maps to row n%4, col n/4.
- FSM states: IDLE, RUN, DONE.
- Reset (rst low, async): state=IDLE, state_reg=0, key_reg=0, rcon=8'h01, round_idx=0, in_ready=1, out_valid=0, out_block=0, busy=0.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready at edge t: state_reg <= in_block ^ in_key, key_reg <= in_key, rcon <= 8'h01, round_idx <= 1, go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle, the next round key is computed combinationally from key_reg and rcon:
    - w0' = w0 ^ SubWord(RotWord(w3)) ^ {rcon,24'h0}
    - w1' = w1 ^ w0'
    - w2' = w2 ^ w1'
    - w3' = w3 ^ w2'
  - round_idx 1–9: state_reg <= standard_round(state_reg, next_key).
  - round_idx 10: state_reg <= final_round(state_reg, next_key), i.e. SubBytes → ShiftRows → AddRoundKey.
  - Every RUN edge: key_reg <= next_key, rcon <= xtime(rcon) (so 8'h80 → 8'h1b → 8'h36), round_idx <= round_idx+1.
  - Leaving round 10: go to DONE, round_idx <= 0.
- DONE:
  - out_valid=1, out_block=state_reg, held stable until out_ready.
  - On out_ready: go to IDLE, out_valid=0 at the next cycle.
  - in_ready stays 0 in DONE; no overlap with a new block.
- Latency: accept edge t → out_valid high from the cycle after edge t+10, i.e. 11 edges after acceptance. Throughput is one block per 12 cycles with out_ready held high.
- in_key and in_block are sampled only at acceptance; later changes have no effect.
- flush:
  - In any state, flush high at an edge forces IDLE, out_valid=0, round_idx=0.
  - flush has priority over acceptance and over output handshake.
  - If flush and in_valid are both high in IDLE, the block is not accepted; in_ready still reads 1 combinationally, and the source must treat flush as a drop.
- out_valid must never fall without out_ready or flush.
- busy = (state != IDLE).
- Reset asserted mid-RUN or in DONE: immediate return to reset values; the partial block is lost.

Test Plan:
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff → out_block 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid exactly 11 edges after acceptance.
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 → 3925841d02dc09fbdc118597196a0b32. Intermediate check: key_reg after round 1 = a0fafe1788542cb123a339392a6c7605.
- Output backpressure: hold out_ready=0 for 20 cycles in DONE → out_valid and out_block stable, in_ready=0. Raise out_ready → IDLE next cycle, in_ready=1.
- Back-to-back: two blocks with in_valid held high and out_ready=1 → both ciphertexts correct, second accepted 12 cycles after the first. Change in_block/in_key during RUN → result unaffected.
- flush at round_idx=5 → IDLE next cycle, no out_valid pulse, following block correct. flush during DONE → out_valid drops, no transfer.
- Assert rst low asynchronously mid-RUN (between edges) → outputs reach reset values immediately. After release, C.1 vector passes.
